// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one operand pair per valid/ready handshake,
// WIDTH+1 shift/add iterations, product held until the consumer accepts it.
module booth_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               busy
);
    // One guard bit lets unsigned operands ride through the signed Booth datapath.
    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LOAD = CW'(E);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state_reg;
    logic [E-1:0]       m_reg;
    logic [E-1:0]       q_reg;
    logic               q_1_reg;
    logic [E:0]         acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] y_reg;

    logic [E-1:0]       a_ext;
    logic [E-1:0]       b_ext;
    logic [E:0]         m_sext;
    logic [E:0]         acc_sum;
    logic [E:0]         acc_next;
    logic [E-1:0]       q_next;
    logic               q_1_next;
    logic [2*WIDTH-1:0] y_next;

    assign a_ext = {tc & a[WIDTH-1], a};
    assign b_ext = {tc & b[WIDTH-1], b};

    always_comb begin
        m_sext = {m_reg[E-1], m_reg};
        case ({q_reg[0], q_1_reg})
            2'b01:   acc_sum = acc_reg + m_sext;
            2'b10:   acc_sum = acc_reg - m_sext;
            default: acc_sum = acc_reg;
        endcase
        // Arithmetic shift of {ACC,Q,q_1}: the ACC sign bit is replicated.
        acc_next = {acc_sum[E], acc_sum[E:1]};
        q_next   = {acc_sum[0], q_reg[E-1:1]};
        q_1_next = q_reg[0];
        // Low 2*WIDTH bits of {ACC,Q} after the final shift.
        y_next   = {acc_next[WIDTH-2:0], q_next};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            m_reg     <= '0;
            q_reg     <= '0;
            q_1_reg   <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            y_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        m_reg     <= a_ext;
                        q_reg     <= b_ext;
                        q_1_reg   <= 1'b0;
                        acc_reg   <= '0;
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_reg <= acc_next;
                    q_reg   <= q_next;
                    q_1_reg <= q_1_next;
                    cnt_reg <= cnt_reg - CNT_ONE;
                    // y is only written here, so it holds between transactions.
                    if (cnt_reg == CNT_ONE) begin
                        y_reg     <= y_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_CALC) || (state_reg == ST_DONE);
    assign y         = y_reg;

endmodule
